// File: rtl/power_mode_controller_if.sv
// Signal bundle between the power mode controller and its environment.
// The debug_force_on signal exists only when PMC_DEBUG_FORCE_ON_EN is defined.
interface power_mode_controller_if;
  logic       clocks_stable;
  logic       filter_busy;
  logic       adc_busy;
  logic       comm_busy;
  logic       filter_req;
  logic       adc_req;
  logic       comm_req;
  logic       sleep_req;
  logic       wake_event;
`ifdef PMC_DEBUG_FORCE_ON_EN
  logic       debug_force_on;
`endif
  logic       system_enable;
  logic       filter_clock_enable;
  logic       adc_clock_enable;
  logic       comm_clock_enable;
  logic       filter_ready;
  logic       adc_ready;
  logic       comm_ready;
  logic       sleep_ack;
  logic [2:0] power_state;

  modport master (
`ifdef PMC_DEBUG_FORCE_ON_EN
    output debug_force_on,
`endif
    output clocks_stable, filter_busy, adc_busy, comm_busy,
    output filter_req, adc_req, comm_req, sleep_req, wake_event,
    input  system_enable, filter_clock_enable, adc_clock_enable, comm_clock_enable,
    input  filter_ready, adc_ready, comm_ready, sleep_ack, power_state
  );

  modport slave (
`ifdef PMC_DEBUG_FORCE_ON_EN
    input  debug_force_on,
`endif
    input  clocks_stable, filter_busy, adc_busy, comm_busy,
    input  filter_req, adc_req, comm_req, sleep_req, wake_event,
    output system_enable, filter_clock_enable, adc_clock_enable, comm_clock_enable,
    output filter_ready, adc_ready, comm_ready, sleep_ack, power_state
  );
endinterface

// File: rtl/power_mode_controller.sv
// Sleep/wake sequencer driving the clock/reset manager's system and domain clock enables.
// Define PMC_DEBUG_FORCE_ON_EN to add debug_force_on (forces all enables on, blocks sleep).
//
// state | meaning
// INIT  | waiting for clocks_stable, domains gated
// RUN   | domains gated on per-domain idle timeout
// DRAIN | domains gated, waiting DRAIN_CYCLES before dropping system_enable
// SLEEP | system_enable low, sleep_ack high, waiting for a wake source
// WAKE  | system_enable back high, waiting WAKE_CYCLES before RUN
module power_mode_controller #(
  parameter int IDLE_TIMEOUT = 16,
  parameter int GATE_LAT     = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int WAKE_CYCLES  = 4
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  power_mode_controller_if.slave  bus
);
  typedef enum logic [2:0] {
    INIT  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    SLEEP = 3'd3,
    WAKE  = 3'd4
  } state_t;

  localparam logic [7:0] IDLE_TC    = 8'(IDLE_TIMEOUT);
  localparam logic [7:0] GATE_TC    = 8'(GATE_LAT);
  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0] WAKE_LOAD  = 8'(WAKE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] phase_tmr;
  logic [7:0] idle_cnt [3];
  logic [7:0] rdy_cnt  [3];
  logic [7:0] idle_nxt [3];
  logic [7:0] rdy_inc  [3];
  logic [2:0] en_nxt;
  logic [2:0] dom_en;
  logic [2:0] dom_rdy;
  logic       sys_en;
  logic       ack;

  logic [2:0] busy;
  logic [2:0] req;
  logic       any_busy;
  logic       any_req;
  logic       force_on;
  logic       stay_run;

  assign busy     = {bus.comm_busy, bus.adc_busy, bus.filter_busy};
  assign req      = {bus.comm_req,  bus.adc_req,  bus.filter_req};
  assign any_busy = |busy;
  assign any_req  = |req;
  assign stay_run = (state == RUN) && (state_nxt == RUN);

`ifdef PMC_DEBUG_FORCE_ON_EN
  assign force_on = bus.debug_force_on;
`else
  assign force_on = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (bus.clocks_stable) state_nxt = RUN;
      RUN:     if (bus.sleep_req && !any_busy && !any_req && !force_on) state_nxt = DRAIN;
      DRAIN: begin
        if (any_busy || any_req)    state_nxt = RUN;
        else if (phase_tmr == 8'd0) state_nxt = SLEEP;
      end
      SLEEP:   if (bus.wake_event || any_req || force_on) state_nxt = WAKE;
      WAKE:    if (phase_tmr == 8'd0) state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Enables are 1 whenever the idle counter will not sit at the timeout after this edge.
  always_comb begin
    en_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      idle_nxt[i] = '0;
      rdy_inc[i]  = '0;
      if (busy[i] || req[i])        idle_nxt[i] = '0;
      else if (idle_cnt[i] >= IDLE_TC) idle_nxt[i] = IDLE_TC;
      else                          idle_nxt[i] = idle_cnt[i] + 8'd1;
      rdy_inc[i] = (rdy_cnt[i] >= GATE_TC) ? GATE_TC : rdy_cnt[i] + 8'd1;
      en_nxt[i]  = force_on || (stay_run && (idle_nxt[i] != IDLE_TC));
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state     <= INIT;
      phase_tmr <= '0;
      dom_en    <= '0;
      dom_rdy   <= '0;
      sys_en    <= 1'b1;
      ack       <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        idle_cnt[i] <= '0;
        rdy_cnt[i]  <= '0;
      end
    end else begin
      state <= state_nxt;
      unique case (state_nxt)
        DRAIN:   phase_tmr <= (state == DRAIN) ? phase_tmr - 8'd1 : DRAIN_LOAD;
        WAKE:    phase_tmr <= (state == WAKE)  ? phase_tmr - 8'd1 : WAKE_LOAD;
        default: phase_tmr <= '0;
      endcase
      // Ready tracks how long the enable has already been high before this edge.
      for (int i = 0; i < 3; i++) begin
        idle_cnt[i] <= stay_run ? idle_nxt[i] : 8'd0;
        rdy_cnt[i]  <= (en_nxt[i] && dom_en[i]) ? rdy_inc[i] : 8'd0;
        dom_rdy[i]  <= en_nxt[i] && dom_en[i] && (rdy_inc[i] == GATE_TC);
      end
      dom_en <= en_nxt;
      sys_en <= force_on || (state_nxt != SLEEP);
      ack    <= (state_nxt == SLEEP);
    end
  end

  assign bus.system_enable       = sys_en;
  assign bus.filter_clock_enable = dom_en[0];
  assign bus.adc_clock_enable    = dom_en[1];
  assign bus.comm_clock_enable   = dom_en[2];
  assign bus.filter_ready        = dom_rdy[0];
  assign bus.adc_ready           = dom_rdy[1];
  assign bus.comm_ready          = dom_rdy[2];
  assign bus.sleep_ack           = ack;
  assign bus.power_state         = state;
endmodule

// File: tb/tb_power_mode_controller.sv
// Directed plus randomized bench for power_mode_controller against a cycle-level reference model.
module tb_power_mode_controller;
  localparam int IDLE_TIMEOUT = 16;
  localparam int GATE_LAT     = 2;
  localparam int DRAIN_CYCLES = 4;
  localparam int WAKE_CYCLES  = 4;

  localparam int S_INIT = 0, S_RUN = 1, S_DRAIN = 2, S_SLEEP = 3, S_WAKE = 4;

  logic clock_in = 1'b0;
  logic reset_in = 1'b1;

  power_mode_controller_if bus();

  power_mode_controller #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .GATE_LAT    (GATE_LAT),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .WAKE_CYCLES (WAKE_CYCLES)
  ) dut (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .bus     (bus)
  );

  always #5 clock_in = ~clock_in;

  int checks = 0;
  int errors = 0;

  // Reference model: state plus "cycles spent in state", idle run length and enable-on time per domain.
  int m_state, m_in_state;
  int m_idle [3];
  int m_on   [3];
  bit m_en   [3];
  bit m_rdy  [3];
  bit m_sys, m_ack;

  function automatic bit force_now();
`ifdef PMC_DEBUG_FORCE_ON_EN
    return bus.debug_force_on;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_update();
    bit b[3], r[3];
    bit any_b, any_r, frc, new_en;
    int nx;
    b = '{bus.filter_busy, bus.adc_busy, bus.comm_busy};
    r = '{bus.filter_req,  bus.adc_req,  bus.comm_req};
    any_b = b[0] | b[1] | b[2];
    any_r = r[0] | r[1] | r[2];
    frc = force_now();
    if (reset_in) begin
      m_state = S_INIT; m_in_state = 1; m_sys = 1; m_ack = 0;
      for (int d = 0; d < 3; d++) begin
        m_idle[d] = 0; m_on[d] = 0; m_en[d] = 0; m_rdy[d] = 0;
      end
      return;
    end
    nx = m_state;
    case (m_state)
      S_INIT:  if (bus.clocks_stable) nx = S_RUN;
      S_RUN:   if (bus.sleep_req && !any_b && !any_r && !frc) nx = S_DRAIN;
      S_DRAIN: if (any_b || any_r) nx = S_RUN;
               else if (m_in_state >= DRAIN_CYCLES) nx = S_SLEEP;
      S_SLEEP: if (bus.wake_event || any_r || frc) nx = S_WAKE;
      S_WAKE:  if (m_in_state >= WAKE_CYCLES) nx = S_RUN;
      default: nx = S_INIT;
    endcase
    for (int d = 0; d < 3; d++) begin
      if (m_state == S_RUN && nx == S_RUN)
        m_idle[d] = (b[d] || r[d]) ? 0 : ((m_idle[d] + 1 > IDLE_TIMEOUT) ? IDLE_TIMEOUT : m_idle[d] + 1);
      else
        m_idle[d] = 0;
      new_en   = frc || (m_state == S_RUN && nx == S_RUN && m_idle[d] < IDLE_TIMEOUT);
      m_on[d]  = new_en ? (m_en[d] ? m_on[d] + 1 : 1) : 0;
      m_en[d]  = new_en;
      m_rdy[d] = new_en && (m_on[d] - 1 >= GATE_LAT);
    end
    m_sys = frc || (nx != S_SLEEP);
    m_ack = (nx == S_SLEEP);
    m_in_state = (nx == m_state) ? m_in_state + 1 : 1;
    m_state = nx;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
  endtask

  task automatic check_all();
    chk("power_state",  8'(bus.power_state),       8'(m_state));
    chk("system_en",    8'(bus.system_enable),     8'(m_sys));
    chk("sleep_ack",    8'(bus.sleep_ack),         8'(m_ack));
    chk("filter_en",    8'(bus.filter_clock_enable), 8'(m_en[0]));
    chk("adc_en",       8'(bus.adc_clock_enable),  8'(m_en[1]));
    chk("comm_en",      8'(bus.comm_clock_enable), 8'(m_en[2]));
    chk("filter_rdy",   8'(bus.filter_ready),      8'(m_rdy[0]));
    chk("adc_rdy",      8'(bus.adc_ready),         8'(m_rdy[1]));
    chk("comm_rdy",     8'(bus.comm_ready),        8'(m_rdy[2]));
  endtask

  task automatic step();
    @(posedge clock_in);
    model_update();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic idle_inputs();
    bus.filter_busy = 0; bus.adc_busy = 0; bus.comm_busy = 0;
    bus.filter_req  = 0; bus.adc_req  = 0; bus.comm_req  = 0;
    bus.sleep_req   = 0; bus.wake_event = 0;
  endtask

  int level [3];

  initial begin
    idle_inputs();
    bus.clocks_stable = 0;
`ifdef PMC_DEBUG_FORCE_ON_EN
    bus.debug_force_on = 0;
`endif
    reset_in = 1;
    run(3);
    chk("rst_state",  8'(bus.power_state), 8'd0);
    chk("rst_sys_en", 8'(bus.system_enable), 8'd1);
    chk("rst_ack",    8'(bus.sleep_ack), 8'd0);
    chk("rst_en",     8'({bus.filter_clock_enable, bus.adc_clock_enable, bus.comm_clock_enable}), 8'd0);
    reset_in = 0;

    // clocks_stable arrives after 10 cycles in INIT
    run(10);
    chk("init_hold", 8'(bus.power_state), 8'd0);
    bus.clocks_stable = 1;
    step();
    chk("run_entry", 8'(bus.power_state), 8'd1);
    step();
    chk("run_en_all", 8'({bus.filter_clock_enable, bus.adc_clock_enable, bus.comm_clock_enable}), 8'd7);
    chk("run_rdy_lo", 8'(bus.filter_ready), 8'd0);
    run(2);
    chk("run_rdy_all", 8'({bus.filter_ready, bus.adc_ready, bus.comm_ready}), 8'd7);

    // filter idles out while adc stays busy
    bus.adc_busy = 1;
    run(20);
    chk("filter_idle_en",  8'(bus.filter_clock_enable), 8'd0);
    chk("filter_idle_rdy", 8'(bus.filter_ready), 8'd0);
    chk("adc_busy_en",     8'(bus.adc_clock_enable), 8'd1);
    bus.filter_req = 1;
    step();
    bus.filter_req = 0;
    chk("filter_req_en", 8'(bus.filter_clock_enable), 8'd1);
    run(2);
    chk("filter_req_rdy", 8'(bus.filter_ready), 8'd1);

    // sleep_req held off by comm_busy, then drain and sleep
    bus.adc_busy = 0; bus.comm_busy = 1; bus.sleep_req = 1;
    run(5);
    chk("sleep_blocked", 8'(bus.power_state), 8'd1);
    bus.comm_busy = 0;
    step();
    chk("drain_entry", 8'(bus.power_state), 8'd2);
    chk("drain_en", 8'({bus.filter_clock_enable, bus.adc_clock_enable, bus.comm_clock_enable}), 8'd0);
    run(3);
    chk("drain_hold", 8'(bus.power_state), 8'd2);
    step();
    chk("sleep_entry", 8'(bus.power_state), 8'd3);
    chk("sleep_sys",   8'(bus.system_enable), 8'd0);
    chk("sleep_ack",   8'(bus.sleep_ack), 8'd1);

    // adc_req pulse wakes
    bus.adc_req = 1; bus.sleep_req = 0;
    step();
    bus.adc_req = 0;
    chk("wake_entry", 8'(bus.power_state), 8'd4);
    chk("wake_sys",   8'(bus.system_enable), 8'd1);
    run(3);
    chk("wake_hold", 8'(bus.power_state), 8'd4);
    step();
    chk("wake_run", 8'(bus.power_state), 8'd1);
    step();
    chk("wake_en_all", 8'({bus.filter_clock_enable, bus.adc_clock_enable, bus.comm_clock_enable}), 8'd7);

    // busy pulse aborts DRAIN
    bus.sleep_req = 1;
    step();
    chk("drain2_entry", 8'(bus.power_state), 8'd2);
    step();
    bus.filter_busy = 1; bus.sleep_req = 0;
    step();
    bus.filter_busy = 0;
    chk("drain_abort", 8'(bus.power_state), 8'd1);
    run(2);

    // reset while asleep
    bus.sleep_req = 1;
    run(5);
    chk("sleep2_entry", 8'(bus.power_state), 8'd3);
    reset_in = 1;
    step();
    reset_in = 0; bus.sleep_req = 0;
    chk("rst_sleep_state", 8'(bus.power_state), 8'd0);
    chk("rst_sleep_sys",   8'(bus.system_enable), 8'd1);
    chk("rst_sleep_ack",   8'(bus.sleep_ack), 8'd0);

    // randomized traffic with bursty per-domain activity levels
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0)
        for (int d = 0; d < 3; d++) level[d] = $urandom_range(0, 2);
      bus.filter_busy = (level[0] == 2) ? $urandom_range(0, 1) : (level[0] == 1 && $urandom_range(0, 31) == 0);
      bus.adc_busy    = (level[1] == 2) ? $urandom_range(0, 1) : (level[1] == 1 && $urandom_range(0, 31) == 0);
      bus.comm_busy   = (level[2] == 2) ? $urandom_range(0, 1) : (level[2] == 1 && $urandom_range(0, 31) == 0);
      bus.filter_req  = ($urandom_range(0, 63) == 0);
      bus.adc_req     = ($urandom_range(0, 63) == 0);
      bus.comm_req    = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 19) == 0) bus.sleep_req = ~bus.sleep_req;
      bus.wake_event    = ($urandom_range(0, 39) == 0);
      bus.clocks_stable = ($urandom_range(0, 7) != 0);
      reset_in          = ($urandom_range(0, 299) == 0);
`ifdef PMC_DEBUG_FORCE_ON_EN
      if ($urandom_range(0, 49) == 0) bus.debug_force_on = ~bus.debug_force_on;
`endif
      step();
    end
    reset_in = 0;
    idle_inputs();
    bus.clocks_stable = 1;

`ifdef PMC_DEBUG_FORCE_ON_EN
    bus.debug_force_on = 0;
    reset_in = 1;
    step();
    reset_in = 0;
    run(3);
    bus.debug_force_on = 1; bus.sleep_req = 1;
    run(100);
    chk("dbg_state", 8'(bus.power_state), 8'd1);
    chk("dbg_en", 8'({bus.system_enable, bus.filter_clock_enable, bus.adc_clock_enable, bus.comm_clock_enable}), 8'd15);
    chk("dbg_rdy", 8'({bus.filter_ready, bus.adc_ready, bus.comm_ready}), 8'd7);
    bus.debug_force_on = 0; bus.sleep_req = 0;
`endif
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
